// File: rtl/secant_search.sv
// secant_search: secant-method search for the plant reference i_ref that drives
// the measured plant output to within TOL of desired_q. Each update computes
// c = b - e_b*(b-a)/(e_b-e_a) using a full-precision product and a restoring
// signed divider (one quotient bit per cycle, fixed CALC latency 2*WIDTH+4).
// Optional feature macro: SECANT_WARM_START_EN (seed a from i_ref_setup and b
// from the last converged point).
module secant_search #(
    parameter int WIDTH    = 10,
    parameter int TOL      = 30,
    parameter int MAX_ITER = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [WIDTH-1:0]                desired_q,
    input  logic [WIDTH-1:0]                i_ref_setup,
    input  logic [WIDTH-1:0]                measured_q,
    input  logic                            meas_valid,
    output logic                            meas_req,
    output logic [WIDTH-1:0]                i_ref,
    output logic                            busy,
    output logic                            done,
    output logic                            fail,
    output logic [$clog2(MAX_ITER+1)-1:0]   iter
);
    localparam int S  = WIDTH + 1;          // signed point / error width
    localparam int P  = 2 * S;              // product and quotient width
    localparam int DW = S + 1;              // denominator magnitude width
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int CW = $clog2(2 * WIDTH + 4);
    localparam logic [CW-1:0] CNT_LOAD = '0;
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * WIDTH + 3);
    localparam logic [S-1:0]  TOL_S    = S'(TOL);
    localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PROBE_A = 3'd1,
        PROBE_B = 3'd2,
        CALC    = 3'd3,
        PROBE_C = 3'd4,
        CHECK   = 3'd5
    } state_t;

    state_t                 state_q;
    logic signed [S-1:0]    a_q, b_q, ea_q, eb_q, ec_q;
    logic [WIDTH-1:0]       des_q;
    logic [P-1:0]           div_n_q;        // dividend in, quotient out
    logic [DW-1:0]          div_r_q;        // partial remainder
    logic [DW-1:0]          div_d_q;        // divisor magnitude
    logic                   neg_q;          // quotient sign
    logic                   zero_q;         // denominator was zero
    logic [CW-1:0]          cnt_q;
    logic                   meas_req_q, busy_q, done_q, fail_q;
    logic [WIDTH-1:0]       i_ref_q;
    logic [IW-1:0]          iter_q;
`ifdef SECANT_WARM_START_EN
    logic [WIDTH-1:0]       last_c_q;
`endif

    logic signed [S-1:0]    e_meas_d;
    logic [S-1:0]           ec_abs_d;
    logic signed [S-1:0]    diff_ba_d;
    logic signed [P-1:0]    eb_x_d, diff_x_d, prod_d;
    logic [P-1:0]           num_mag_d;
    logic signed [S:0]      den_d;
    logic [DW-1:0]          den_mag_d;
    logic [DW:0]            rem_shift_d;
    logic                   rem_ge_d;
    logic [DW-1:0]          rem_next_d;
    logic signed [P+1:0]    quot_x_d, quot_d, b_x_d, eb_x2_d, c_full_d;
    logic [WIDTH-1:0]       c_sat_d;
    logic [WIDTH-1:0]       init_a_d, init_b_d;

`ifndef SECANT_WARM_START_EN
    logic unused_setup_s;
    assign unused_setup_s = ^i_ref_setup;
`endif

    // Error capture, secant numerator/denominator, divider step and saturation of c
    always_comb begin
        e_meas_d    = $signed({1'b0, measured_q}) - $signed({1'b0, des_q});
        ec_abs_d    = ec_q[S-1] ? -ec_q : ec_q;
        diff_ba_d   = b_q - a_q;
        eb_x_d      = {{(P-S){eb_q[S-1]}}, eb_q};
        diff_x_d    = {{(P-S){diff_ba_d[S-1]}}, diff_ba_d};
        prod_d      = eb_x_d * diff_x_d;
        num_mag_d   = prod_d[P-1] ? -prod_d : prod_d;
        den_d       = {eb_q[S-1], eb_q} - {ea_q[S-1], ea_q};
        den_mag_d   = den_d[S] ? -den_d : den_d;
        rem_shift_d = {div_r_q, div_n_q[P-1]};
        rem_ge_d    = (rem_shift_d >= {1'b0, div_d_q});
        rem_next_d  = rem_ge_d ? DW'(rem_shift_d - {1'b0, div_d_q}) : rem_shift_d[DW-1:0];
        quot_x_d    = {2'b00, div_n_q};
        quot_d      = neg_q ? -quot_x_d : quot_x_d;
        b_x_d       = {{(P+2-S){b_q[S-1]}}, b_q};
        eb_x2_d     = {{(P+2-S){eb_q[S-1]}}, eb_q};
        c_full_d    = zero_q ? (b_x_d - eb_x2_d) : (b_x_d - quot_d);
        if (c_full_d[P+1]) begin
            c_sat_d = '0;
        end else if (|c_full_d[P:WIDTH]) begin
            c_sat_d = '1;
        end else begin
            c_sat_d = c_full_d[WIDTH-1:0];
        end
`ifdef SECANT_WARM_START_EN
        init_a_d = i_ref_setup;
        init_b_d = (i_ref_setup == last_c_q) ? ~i_ref_setup : last_c_q;
`else
        init_a_d = '0;
        init_b_d = '1;
`endif
    end

    // Search FSM, sequential divider and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            ea_q       <= '0;
            eb_q       <= '0;
            ec_q       <= '0;
            des_q      <= '0;
            div_n_q    <= '0;
            div_r_q    <= '0;
            div_d_q    <= '0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            cnt_q      <= '0;
            meas_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            i_ref_q    <= '0;
            iter_q     <= '0;
`ifdef SECANT_WARM_START_EN
            last_c_q   <= '1;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // a start coinciding with the done pulse is dropped
                    if (start && !done_q) begin
                        a_q        <= {1'b0, init_a_d};
                        b_q        <= {1'b0, init_b_d};
                        i_ref_q    <= init_a_d;
                        des_q      <= desired_q;
                        meas_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                        fail_q     <= 1'b0;
                        iter_q     <= '0;
                        state_q    <= PROBE_A;
                    end
                end
                PROBE_A: begin
                    if (meas_valid) begin
                        ea_q    <= e_meas_d;
                        i_ref_q <= b_q[WIDTH-1:0];
                        state_q <= PROBE_B;
                    end
                end
                PROBE_B: begin
                    if (meas_valid) begin
                        eb_q       <= e_meas_d;
                        meas_req_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LOAD) begin
                        div_n_q <= num_mag_d;
                        div_r_q <= '0;
                        div_d_q <= den_mag_d;
                        neg_q   <= prod_d[P-1] ^ den_d[S];
                        zero_q  <= (den_d == '0);
                    end else if (cnt_q == CNT_LAST) begin
                        i_ref_q    <= c_sat_d;
                        iter_q     <= iter_q + IW'(1);
                        meas_req_q <= 1'b1;
                        state_q    <= PROBE_C;
                    end else begin
                        div_r_q <= rem_next_d;
                        div_n_q <= {div_n_q[P-2:0], rem_ge_d};
                    end
                end
                PROBE_C: begin
                    if (meas_valid) begin
                        ec_q       <= e_meas_d;
                        meas_req_q <= 1'b0;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    if (ec_abs_d < TOL_S) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        fail_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef SECANT_WARM_START_EN
                        last_c_q <= i_ref_q;
`endif
                    end else if (iter_q == ITER_MAX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        fail_q  <= 1'b1;
                        state_q <= IDLE;
`ifdef SECANT_WARM_START_EN
                        last_c_q <= '1;
`endif
                    end else begin
                        a_q     <= b_q;
                        ea_q    <= eb_q;
                        b_q     <= {1'b0, i_ref_q};
                        eb_q    <= ec_q;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign meas_req = meas_req_q;
    assign i_ref    = i_ref_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign iter     = iter_q;

endmodule

// File: tb/tb_secant_search.sv
// Directed testbench for secant_search with a zero-latency behavioural plant.
module tb_secant_search;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] desired_q;
    logic [9:0] i_ref_setup;
    logic [9:0] measured_q = 10'd0;
    logic       meas_valid = 1'b0;
    logic       meas_req;
    logic [9:0] i_ref;
    logic       busy;
    logic       done;
    logic       fail;
    logic [4:0] iter;

    int n_vec  = 0;
    int n_fail = 0;
    int plant_mode = 0;
    bit force_valid = 1'b0;
    int probe_log[$];

    secant_search dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .desired_q  (desired_q),
        .i_ref_setup(i_ref_setup),
        .measured_q (measured_q),
        .meas_valid (meas_valid),
        .meas_req   (meas_req),
        .i_ref      (i_ref),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .iter       (iter)
    );

    always #5 clk = ~clk;

    // mode 0: q=i/4, 1: q=300, 2/3: table plants for saturation, 4: silent, 5: answers only at i=0
    function automatic logic [9:0] plant_q(input int mode, input logic [9:0] i);
        case (mode)
            0: plant_q = i >> 2;
            1: plant_q = 10'd300;
            2: plant_q = (i == 10'd0) ? 10'd110 : ((i == 10'd1023) ? 10'd150 : 10'd100);
            3: plant_q = (i == 10'd0) ? 10'd100 : ((i == 10'd1023) ? 10'd60 : 10'd50);
            default: plant_q = 10'd0;
        endcase
    endfunction

    function automatic bit plant_answers(input int mode, input logic [9:0] i);
        if (mode == 4) return 1'b0;
        if (mode == 5) return (i == 10'd0);
        return 1'b1;
    endfunction

    // Zero-latency plant: responds on the falling edge to the current probe
    always @(negedge clk) begin
        if ((meas_req === 1'b1 && plant_answers(plant_mode, i_ref)) || force_valid) begin
            measured_q = plant_q(plant_mode, i_ref);
            meas_valid = 1'b1;
            if (meas_req === 1'b1) probe_log.push_back(int'(i_ref));
        end else begin
            meas_valid = 1'b0;
        end
    end

    task automatic do_reset(input int mode);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; plant_mode = mode;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_search(input logic [9:0] des, input logic [9:0] setup,
                              output bit got_done, output int busy_cycles);
        @(negedge clk);
        probe_log.delete();
        desired_q = des; i_ref_setup = setup; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got_done = 1'b0; busy_cycles = 0;
        for (int k = 0; k < 3000; k++) begin
            if (done === 1'b1) begin got_done = 1'b1; break; end
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
    endtask

    function automatic int plog(input int idx);
        return (idx < probe_log.size()) ? probe_log[idx] : -1;
    endfunction

    task automatic test_reset;
        @(negedge clk);
        n_vec++; if (meas_req !== 1'b0) begin n_fail++; $display("FAIL reset_meas_req: got %b expected 0", meas_req); end
        n_vec++; if (i_ref !== 10'd0) begin n_fail++; $display("FAIL reset_i_ref: got %0d expected 0", i_ref); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b expected 0", fail); end
        n_vec++; if (iter !== 5'd0) begin n_fail++; $display("FAIL reset_iter: got %0d expected 0", iter); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic;
        bit got; int bc;
        do_reset(0);
        run_search(10'd128, 10'd0, got, bc);
        n_vec++; if (got !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", got); end
        n_vec++; if (iter !== 5'd1) begin n_fail++; $display("FAIL basic_iter: got %0d expected 1", iter); end
        n_vec++; if (i_ref !== 10'd514) begin n_fail++; $display("FAIL basic_i_ref: got %0d expected 514", i_ref); end
        n_vec++; if (fail !== 1'b0) begin n_fail++; $display("FAIL basic_fail: got %b expected 0", fail); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b expected 0", busy); end
        n_vec++; if (bc !== 28) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 28", bc); end
        n_vec++; if (probe_log.size() !== 3) begin n_fail++; $display("FAIL basic_nprobes: got %0d expected 3", probe_log.size()); end
        n_vec++; if (plog(0) !== 0) begin n_fail++; $display("FAIL basic_probe0: got %0d expected 0", plog(0)); end
        n_vec++; if (plog(1) !== 1023) begin n_fail++; $display("FAIL basic_probe1: got %0d expected 1023", plog(1)); end
        n_vec++; if (plog(2) !== 514) begin n_fail++; $display("FAIL basic_probe2: got %0d expected 514", plog(2)); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        n_vec++; if (i_ref !== 10'd514) begin n_fail++; $display("FAIL basic_i_ref_hold: got %0d expected 514", i_ref); end
    endtask

    task automatic test_warm_start;
        bit got; int bc; int exp0; int exp1;
`ifdef SECANT_WARM_START_EN
        exp0 = 400; exp1 = 514;
`else
        exp0 = 0; exp1 = 1023;
`endif
        run_search(10'd128, 10'd400, got, bc);
        n_vec++; if (got !== 1'b1) begin n_fail++; $display("FAIL warm_done: got %b expected 1", got); end
        n_vec++; if (plog(0) !== exp0) begin n_fail++; $display("FAIL warm_probe0: got %0d expected %0d", plog(0), exp0); end
        n_vec++; if (plog(1) !== exp1) begin n_fail++; $display("FAIL warm_probe1: got %0d expected %0d", plog(1), exp1); end
        n_vec++; if (i_ref !== 10'd514) begin n_fail++; $display("FAIL warm_i_ref: got %0d expected 514", i_ref); end
    endtask

    task automatic test_zero_den;
        bit got; int bc;
        do_reset(1);
        run_search(10'd258, 10'd0, got, bc);
        n_vec++; if (got !== 1'b1) begin n_fail++; $display("FAIL zden_done: got %b expected 1", got); end
        n_vec++; if (fail !== 1'b1) begin n_fail++; $display("FAIL zden_fail: got %b expected 1", fail); end
        n_vec++; if (iter !== 5'd16) begin n_fail++; $display("FAIL zden_iter: got %0d expected 16", iter); end
        n_vec++; if (i_ref !== 10'd351) begin n_fail++; $display("FAIL zden_i_ref: got %0d expected 351", i_ref); end
        n_vec++; if (plog(2) !== 981) begin n_fail++; $display("FAIL zden_c1: got %0d expected 981", plog(2)); end
        n_vec++; if (plog(3) !== 939) begin n_fail++; $display("FAIL zden_c2: got %0d expected 939", plog(3)); end
        n_vec++; if (probe_log.size() !== 18) begin n_fail++; $display("FAIL zden_nprobes: got %0d expected 18", probe_log.size()); end
        n_vec++; if (bc !== 418) begin n_fail++; $display("FAIL zden_busy_cycles: got %0d expected 418", bc); end
    endtask

    task automatic test_saturation;
        bit got; int bc;
        do_reset(2);
        run_search(10'd100, 10'd0, got, bc);
        n_vec++; if (got !== 1'b1) begin n_fail++; $display("FAIL sat_lo_done: got %b expected 1", got); end
        n_vec++; if (i_ref !== 10'd0) begin n_fail++; $display("FAIL sat_lo_i_ref: got %0d expected 0", i_ref); end
        n_vec++; if (plog(2) !== 0) begin n_fail++; $display("FAIL sat_lo_probe: got %0d expected 0", plog(2)); end
        n_vec++; if (iter !== 5'd1) begin n_fail++; $display("FAIL sat_lo_iter: got %0d expected 1", iter); end
        do_reset(3);
        run_search(10'd50, 10'd0, got, bc);
        n_vec++; if (got !== 1'b1) begin n_fail++; $display("FAIL sat_hi_done: got %b expected 1", got); end
        n_vec++; if (i_ref !== 10'd1023) begin n_fail++; $display("FAIL sat_hi_i_ref: got %0d expected 1023", i_ref); end
        n_vec++; if (iter !== 5'd1) begin n_fail++; $display("FAIL sat_hi_iter: got %0d expected 1", iter); end
    endtask

    task automatic test_start_ignore;
        bit got;
        do_reset(0);
        @(negedge clk);
        probe_log.delete();
        desired_q = 10'd128; i_ref_setup = 10'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1;                       // lands inside CALC
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (done === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++; if (got !== 1'b1) begin n_fail++; $display("FAIL ign_done: got %b expected 1", got); end
        n_vec++; if (probe_log.size() !== 3) begin n_fail++; $display("FAIL ign_nprobes: got %0d expected 3", probe_log.size()); end
        n_vec++; if (iter !== 5'd1) begin n_fail++; $display("FAIL ign_iter: got %0d expected 1", iter); end
        start = 1'b1;                       // on the done cycle
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_done_start: got busy %b expected 0", busy); end
        @(negedge clk);                     // start held: accepted one cycle after done
        start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_restart_busy: got %b expected 1", busy); end
        n_vec++; if (iter !== 5'd0) begin n_fail++; $display("FAIL ign_restart_iter: got %0d expected 0", iter); end
        got = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (done === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++; if (got !== 1'b1) begin n_fail++; $display("FAIL ign_restart_done: got %b expected 1", got); end
    endtask

    task automatic test_reset_mid;
        bit activity;
        do_reset(5);
        @(negedge clk);
        desired_q = 10'd128; i_ref_setup = 10'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_vec++; if (meas_req !== 1'b1 || i_ref !== 10'd1023) begin n_fail++; $display("FAIL mid_in_probe_b: got meas_req %b i_ref %0d expected 1 1023", meas_req, i_ref); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (meas_req !== 1'b0) begin n_fail++; $display("FAIL mid_meas_req: got %b expected 0", meas_req); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
        n_vec++; if (i_ref !== 10'd0) begin n_fail++; $display("FAIL mid_i_ref: got %0d expected 0", i_ref); end
        @(negedge clk);
        rst = 1'b1;
        force_valid = 1'b1;
        activity = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || meas_req !== 1'b0 || done !== 1'b0 || i_ref !== 10'd0) activity = 1'b1;
        end
        force_valid = 1'b0;
        n_vec++; if (activity !== 1'b0) begin n_fail++; $display("FAIL mid_no_resume: got activity %b expected 0", activity); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; desired_q = 10'd0; i_ref_setup = 10'd0;
        test_reset();
        test_basic();
        test_warm_start();
        test_zero_den();
        test_saturation();
        test_start_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
